// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI types, mode constants and sizing helpers
package spi_pkg;

    // Master sequencer states; HOLD keeps ss_n low between bytes of one frame
    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        HIGH,
        LOW,
        TRAIL,
        HOLD,
        GAP
    } spi_state_t;

    // Mode 0: sclk idles low, data sampled on the leading (rising) edge
    localparam logic SPI_CPOL  = 1'b0;
    localparam logic SPI_CPHA  = 1'b0;

    // Word size shared with the on-board slave receiver
    localparam int   SPI_WIDTH = 8;

    // Counter width able to hold div-1, never narrower than one bit
    function automatic int timer_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// rtl/spi_phase_timer.sv - loadable down-counter timing one sclk half-period
module spi_phase_timer
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 8
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic load,
    input  logic en,
    output logic done
);

    localparam int CW = timer_width(CLK_DIV);

    logic [CW-1:0] count;

    // Load restarts a phase at CLK_DIV-1; while enabled count down and park at 0
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count <= '0;
        end else if (load) begin
            count <= CW'(CLK_DIV - 1);
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    // Last cycle of the current phase
    assign done = en && (count == '0);

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - byte-wide mode 0 SPI master with valid/ready TX and strobed RX
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 8,
    parameter int WIDTH   = SPI_WIDTH
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    input  logic             tx_last,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             sclk,
    output logic             mosi,
    input  logic             miso,
    output logic             ss_n
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    spi_state_t       state;
    logic [WIDTH-1:0] tx_sh;
    logic [WIDTH-1:0] rx_sh;
    logic [BW-1:0]    bit_cnt;
    logic             last_flag;
    logic             phase_done;
    logic             accept;
    logic             timer_load;

    assign accept     = tx_valid && tx_ready;
    assign timer_load = accept || phase_done;

    // busy is high exactly in the timed phases, so it doubles as the timer enable
    spi_phase_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .CLK   (CLK),
        .RST_N (RST_N),
        .load  (timer_load),
        .en    (busy),
        .done  (phase_done)
    );

    // Transfer sequencer; every pin and handshake output is a register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            ss_n      <= 1'b1;
            sclk      <= SPI_CPOL;
            mosi      <= 1'b0;
            tx_ready  <= 1'b1;
            rx_valid  <= 1'b0;
            rx_data   <= '0;
            busy      <= 1'b0;
            tx_sh     <= '0;
            rx_sh     <= '0;
            bit_cnt   <= '0;
            last_flag <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE, HOLD: begin
                    if (accept) begin
                        tx_sh     <= tx_data;
                        last_flag <= tx_last;
                        bit_cnt   <= BW'(WIDTH - 1);
                        ss_n      <= 1'b0;
                        mosi      <= tx_data[WIDTH-1];
                        tx_ready  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= LEAD;
                    end
                end
                LEAD, LOW: begin
                    if (phase_done) begin
                        sclk <= ~SPI_CPOL;
                        if (SPI_CPHA == 1'b0) begin
                            rx_sh <= {rx_sh[WIDTH-2:0], miso};
                        end
                        state <= HIGH;
                    end
                end
                HIGH: begin
                    if (phase_done) begin
                        sclk <= SPI_CPOL;
                        if (bit_cnt == '0) begin
                            state <= TRAIL;
                        end else begin
                            mosi    <= tx_sh[WIDTH-2];
                            tx_sh   <= tx_sh << 1;
                            bit_cnt <= bit_cnt - 1'b1;
                            state   <= LOW;
                        end
                    end
                end
                TRAIL: begin
                    if (phase_done) begin
                        rx_data  <= rx_sh;
                        rx_valid <= 1'b1;
                        if (last_flag) begin
                            ss_n  <= 1'b1;
                            state <= GAP;
                        end else begin
                            tx_ready <= 1'b1;
                            busy     <= 1'b0;
                            state    <= HOLD;
                        end
                    end
                end
                GAP: begin
                    if (phase_done) begin
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - directed self-checking bench for spi_master
module tb_spi_master;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;

    int checks = 0;
    int errors = 0;

    // CLK_DIV=2 instance
    logic [7:0] tx_data2  = 8'h00;
    logic       tx_valid2 = 1'b0;
    logic       tx_last2  = 1'b0;
    logic       tx_ready2, rx_valid2, busy2, sclk2, mosi2, ss_n2, miso2;
    logic [7:0] rx_data2;

    // CLK_DIV=1 instance, miso tied high
    logic [7:0] tx_data1  = 8'h00;
    logic       tx_valid1 = 1'b0;
    logic       tx_last1  = 1'b0;
    logic       miso1     = 1'b1;
    logic       tx_ready1, rx_valid1, busy1, sclk1, mosi1, ss_n1;
    logic [7:0] rx_data1;

    // Bench slave for the CLK_DIV=2 instance
    logic        loop_en   = 1'b0;
    logic [31:0] slv_word  = 32'h0;
    int          fall_base = 0;
    int          fall_cnt2 = 0;
    int          rise_cnt2 = 0;
    int          rise_cnt1 = 0;
    logic [31:0] cap2      = 32'h0;
    logic [7:0]  cap1      = 8'h0;
    logic        slv_bit;

    always #5 CLK = ~CLK;

    always @(posedge sclk2) begin
        rise_cnt2 <= rise_cnt2 + 1;
        cap2      <= {cap2[30:0], mosi2};
    end

    always @(negedge sclk2) fall_cnt2 <= fall_cnt2 + 1;

    always @(posedge sclk1) begin
        rise_cnt1 <= rise_cnt1 + 1;
        cap1      <= {cap1[6:0], mosi1};
    end

    always_comb begin
        int idx;
        idx     = fall_cnt2 - fall_base;
        slv_bit = 1'b0;
        if (idx >= 0 && idx < 32) slv_bit = slv_word[31-idx];
    end

    assign miso2 = loop_en ? mosi2 : slv_bit;

    spi_master #(.CLK_DIV(2), .WIDTH(8)) u_dut2 (
        .CLK(CLK), .RST_N(RST_N), .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_last(tx_last2),
        .tx_ready(tx_ready2), .rx_data(rx_data2), .rx_valid(rx_valid2), .busy(busy2),
        .sclk(sclk2), .mosi(mosi2), .miso(miso2), .ss_n(ss_n2)
    );

    spi_master #(.CLK_DIV(1), .WIDTH(8)) u_dut1 (
        .CLK(CLK), .RST_N(RST_N), .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_last(tx_last1),
        .tx_ready(tx_ready1), .rx_data(rx_data1), .rx_valid(rx_valid1), .busy(busy1),
        .sclk(sclk1), .mosi(mosi1), .miso(miso1), .ss_n(ss_n1)
    );

    task automatic send2(input logic [7:0] d, input logic last, output int lat, output logic [7:0] rx);
        int w;
        @(negedge CLK);
        tx_data2 = d; tx_last2 = last; tx_valid2 = 1'b1;
        w = 0;
        while (tx_ready2 !== 1'b1 && w < 500) begin @(negedge CLK); w++; end
        @(posedge CLK); #1;
        tx_valid2 = 1'b0; tx_data2 = 8'h00;
        lat = 0; rx = 8'h00;
        while (lat < 500) begin
            @(negedge CLK); lat++;
            if (rx_valid2 === 1'b1) begin rx = rx_data2; break; end
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if ({ss_n2, sclk2, mosi2, tx_ready2, rx_valid2, busy2, rx_data2} !== {6'b100100, 8'h00}) begin
            errors++;
            $display("FAIL reset_div2: got ss/sclk/mosi/rdy/rxv/busy/rx=%b %h want 100100 00",
                     {ss_n2, sclk2, mosi2, tx_ready2, rx_valid2, busy2}, rx_data2);
        end
        checks++;
        if ({ss_n1, sclk1, mosi1, tx_ready1, rx_valid1, busy1, rx_data1} !== {6'b100100, 8'h00}) begin
            errors++;
            $display("FAIL reset_div1: got %b %h want 100100 00",
                     {ss_n1, sclk1, mosi1, tx_ready1, rx_valid1, busy1}, rx_data1);
        end
        RST_N = 1'b1;
    endtask

    task automatic test_single();
        int lat, r0;
        logic [7:0] rx;
        fall_base = fall_cnt2; slv_word = {8'h3C, 24'h0}; r0 = rise_cnt2;
        send2(8'hA5, 1'b1, lat, rx);
        checks++;
        if (lat !== 35) begin errors++; $display("FAIL single_latency: got %0d want 35", lat); end
        checks++;
        if (rx !== 8'h3C) begin errors++; $display("FAIL single_rx: got %h want 3c", rx); end
        checks++;
        if (cap2[7:0] !== 8'hA5) begin errors++; $display("FAIL single_mosi: got %h want a5", cap2[7:0]); end
        checks++;
        if (rise_cnt2 - r0 !== 8) begin errors++; $display("FAIL single_pulses: got %0d want 8", rise_cnt2 - r0); end
        checks++;
        if ({ss_n2, tx_ready2} !== 2'b10) begin errors++; $display("FAIL gap_c0: got ss/rdy=%b want 10", {ss_n2, tx_ready2}); end
        @(negedge CLK);
        checks++;
        if ({ss_n2, tx_ready2} !== 2'b10) begin errors++; $display("FAIL gap_c1: got ss/rdy=%b want 10", {ss_n2, tx_ready2}); end
        @(negedge CLK);
        checks++;
        if ({ss_n2, tx_ready2, busy2} !== 3'b110) begin errors++; $display("FAIL gap_end: got ss/rdy/busy=%b want 110", {ss_n2, tx_ready2, busy2}); end
    endtask

    task automatic test_burst();
        logic [7:0] bd [3];
        logic       bl [3];
        logic [7:0] rxd [3];
        int sent, rxn, glitch, r0;
        bd = '{8'h01, 8'h02, 8'h03};
        bl = '{1'b0, 1'b0, 1'b1};
        rxd = '{8'h00, 8'h00, 8'h00};
        fall_base = fall_cnt2; slv_word = 32'hC35A9600; r0 = rise_cnt2;
        sent = 0; rxn = 0; glitch = 0;
        @(negedge CLK);
        tx_data2 = bd[0]; tx_last2 = bl[0]; tx_valid2 = 1'b1;
        for (int c = 0; c < 600 && rxn < 3; c++) begin
            if (tx_valid2 && tx_ready2 === 1'b1) begin
                @(posedge CLK); #1;
                sent++;
                if (sent < 3) begin tx_data2 = bd[sent]; tx_last2 = bl[sent]; end
                else tx_valid2 = 1'b0;
            end
            @(negedge CLK);
            if (sent > 0 && ss_n2 !== 1'b0 && !(rx_valid2 === 1'b1 && rxn == 2)) glitch++;
            if (rx_valid2 === 1'b1) begin rxd[rxn] = rx_data2; rxn++; end
        end
        tx_valid2 = 1'b0;
        checks++;
        if (rxn !== 3 || sent !== 3) begin errors++; $display("FAIL burst_count: got rx=%0d sent=%0d want 3 3", rxn, sent); end
        checks++;
        if (glitch !== 0) begin errors++; $display("FAIL burst_ss_n: got %0d high cycles want 0", glitch); end
        checks++;
        if (ss_n2 !== 1'b1) begin errors++; $display("FAIL burst_ss_release: got %b want 1", ss_n2); end
        checks++;
        if (rise_cnt2 - r0 !== 24) begin errors++; $display("FAIL burst_pulses: got %0d want 24", rise_cnt2 - r0); end
        checks++;
        if (cap2[23:0] !== 24'h010203) begin errors++; $display("FAIL burst_mosi: got %h want 010203", cap2[23:0]); end
        checks++;
        if ({rxd[0], rxd[1], rxd[2]} !== 24'hC35A96) begin
            errors++; $display("FAIL burst_rx: got %h%h%h want c35a96", rxd[0], rxd[1], rxd[2]);
        end
    endtask

    task automatic test_back_pressure();
        int w, bad, lat;
        logic [7:0] rx;
        fall_base = fall_cnt2; slv_word = {8'h0F, 8'hF0, 16'h0};
        @(negedge CLK);
        tx_data2 = 8'h81; tx_last2 = 1'b0; tx_valid2 = 1'b1;
        w = 0;
        while (tx_ready2 !== 1'b1 && w < 500) begin @(negedge CLK); w++; end
        @(posedge CLK); #1;
        tx_valid2 = 1'b0;
        w = 0;
        while (sclk2 !== 1'b1 && w < 100) begin @(negedge CLK); w++; end
        tx_data2 = 8'h77; tx_last2 = 1'b1; tx_valid2 = 1'b1;
        bad = 0; w = 0;
        while (rx_valid2 !== 1'b1 && w < 300) begin
            if (tx_ready2 !== 1'b0) bad++;
            @(negedge CLK); w++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL bp_ready_busy: got %0d ready cycles want 0", bad); end
        checks++;
        if (rx_data2 !== 8'h0F || cap2[7:0] !== 8'h81) begin
            errors++; $display("FAIL bp_first: got rx=%h mosi=%h want 0f 81", rx_data2, cap2[7:0]);
        end
        checks++;
        if ({tx_ready2, ss_n2} !== 2'b10) begin errors++; $display("FAIL bp_hold: got rdy/ss=%b want 10", {tx_ready2, ss_n2}); end
        @(posedge CLK); #1;
        tx_valid2 = 1'b0;
        lat = 0; rx = 8'h00;
        while (lat < 500) begin
            @(negedge CLK); lat++;
            if (rx_valid2 === 1'b1) begin rx = rx_data2; break; end
        end
        checks++;
        if (lat !== 35 || rx !== 8'hF0 || cap2[7:0] !== 8'h77) begin
            errors++; $display("FAIL bp_second: got lat=%0d rx=%h mosi=%h want 35 f0 77", lat, rx, cap2[7:0]);
        end
    endtask

    task automatic test_reset_mid();
        int w, r0, saw_rx, lat;
        logic [7:0] rx;
        fall_base = fall_cnt2; slv_word = {8'h99, 24'h0}; r0 = rise_cnt2;
        @(negedge CLK);
        tx_data2 = 8'h55; tx_last2 = 1'b1; tx_valid2 = 1'b1;
        w = 0;
        while (tx_ready2 !== 1'b1 && w < 500) begin @(negedge CLK); w++; end
        @(posedge CLK); #1;
        tx_valid2 = 1'b0;
        saw_rx = 0; w = 0;
        while ((rise_cnt2 - r0) < 4 && w < 200) begin
            @(negedge CLK); w++;
            if (rx_valid2 === 1'b1) saw_rx++;
        end
        #2 RST_N = 1'b0;
        #1;
        checks++;
        if ({ss_n2, sclk2, busy2, tx_ready2, rx_valid2, rx_data2} !== {5'b10010, 8'h00}) begin
            errors++; $display("FAIL mid_reset_async: got ss/sclk/busy/rdy/rxv=%b rx=%h want 10010 00",
                               {ss_n2, sclk2, busy2, tx_ready2, rx_valid2}, rx_data2);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (40) begin
            @(negedge CLK);
            if (rx_valid2 === 1'b1) saw_rx++;
        end
        checks++;
        if (saw_rx !== 0) begin errors++; $display("FAIL mid_reset_rx_valid: got %0d strobes want 0", saw_rx); end
        fall_base = fall_cnt2; slv_word = {8'h6B, 24'h0};
        send2(8'hFF, 1'b1, lat, rx);
        checks++;
        if (lat !== 35 || rx !== 8'h6B || cap2[7:0] !== 8'hFF) begin
            errors++; $display("FAIL mid_reset_next: got lat=%0d rx=%h mosi=%h want 35 6b ff", lat, rx, cap2[7:0]);
        end
    endtask

    task automatic test_div1();
        int w, lat, bad, r1;
        @(negedge CLK);
        tx_data1 = 8'h80; tx_last1 = 1'b1; tx_valid1 = 1'b1;
        w = 0;
        while (tx_ready1 !== 1'b1 && w < 500) begin @(negedge CLK); w++; end
        r1 = rise_cnt1;
        @(posedge CLK); #1;
        tx_valid1 = 1'b0;
        lat = 0; bad = 0;
        while (lat < 100) begin
            @(negedge CLK); lat++;
            if (lat <= 17 && sclk1 !== ((lat % 2 == 0) && (lat <= 16))) bad++;
            if (rx_valid1 === 1'b1) break;
        end
        checks++;
        if (lat !== 18) begin errors++; $display("FAIL div1_latency: got %0d want 18", lat); end
        checks++;
        if (rx_data1 !== 8'hFF) begin errors++; $display("FAIL div1_rx: got %h want ff", rx_data1); end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL div1_sclk_toggle: got %0d bad cycles want 0", bad); end
        checks++;
        if (rise_cnt1 - r1 !== 8 || cap1 !== 8'h80) begin
            errors++; $display("FAIL div1_mosi: got pulses=%0d mosi=%h want 8 80", rise_cnt1 - r1, cap1);
        end
    endtask

    task automatic test_loopback();
        logic [7:0] lb [3];
        int lat;
        logic [7:0] rx;
        lb = '{8'h00, 8'hFF, 8'h5A};
        loop_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send2(lb[i], 1'b1, lat, rx);
            checks++;
            if (rx !== lb[i] || lat !== 35) begin
                errors++; $display("FAIL loopback_%0d: got rx=%h lat=%0d want %h 35", i, rx, lat, lb[i]);
            end
        end
        loop_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_back_pressure();
        test_reset_mid();
        test_div1();
        test_loopback();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
